lfsr_descrambler_sync: RTL and testbench

//  Receive-side counterpart of the 195-bit primary LFSR scrambler. It hunts for an in-band sync marker.
//  It then captures a 195-bit seed sent in-band and runs a local copy of the same Galois LFSR.

---
 rtl/lfsr_descrambler_sync.sv | 140 ++++++++++++++
 tb/tb_lfsr_descrambler_sync.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_descrambler_sync.sv
// Receive-side descrambler for the 195-bit Galois LFSR scrambler.
// The block hunts for repeated sync markers and then captures an in-band seed.
// It then XORs every data beat with the locally generated keystream.
module lfsr_descrambler_sync #(
    parameter int unsigned POLY_WIDTH                   = 195,
    parameter int unsigned NUM_OF_STEPS                 = 10,
    parameter logic [NUM_OF_STEPS-1:0] SYNC_PATTERN     = 10'h17C,
    parameter int unsigned SYNC_REPEAT                  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    resync,
    input  logic                    din_valid,
    input  logic [NUM_OF_STEPS-1:0] din,
    output logic                    dout_valid,
    output logic [NUM_OF_STEPS-1:0] dout,
    output logic                    locked,
    output logic                    seed_err,
    output logic [POLY_WIDTH-1:0]   lfsr_state
);

    localparam int unsigned SEED_BEATS = (POLY_WIDTH + NUM_OF_STEPS - 1) / NUM_OF_STEPS;
    localparam int unsigned MCNT_W     = 3;
    localparam int unsigned WCNT_W     = $clog2(SEED_BEATS);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                  state;
    logic [MCNT_W-1:0]       mcnt;
    logic [WCNT_W-1:0]       wcnt;
    logic [POLY_WIDTH-1:0]   seed_sh;
    logic [POLY_WIDTH-1:0]   seed_next;
    logic [POLY_WIDTH-1:0]   s_walk;
    logic [POLY_WIDTH-1:0]   s_end;
    logic [NUM_OF_STEPS-1:0] ks;

    // One Galois step: feedback bit s[msb] enters bit 0 and the three taps.
    function automatic logic [POLY_WIDTH-1:0] lfsr_step(input logic [POLY_WIDTH-1:0] s);
        logic [POLY_WIDTH-1:0] n;
        logic                  fb;
        fb    = s[POLY_WIDTH-1];
        n     = {s[POLY_WIDTH-2:0], fb};
        n[28] = s[27] ^ fb;
        n[41] = s[40] ^ fb;
        n[68] = s[67] ^ fb;
        return n;
    endfunction

    // Keystream for one beat and the state after NUM_OF_STEPS steps.
    always_comb begin
        ks     = '0;
        s_walk = lfsr_state;
        for (int j = 0; j < int'(NUM_OF_STEPS); j++) begin
            ks[j]  = s_walk[POLY_WIDTH-1];
            s_walk = lfsr_step(s_walk);
        end
        s_end = s_walk;
    end

    // Shadow seed with the current beat merged into its slice; the top beat is truncated.
    always_comb begin
        seed_next = seed_sh;
        for (int unsigned i = 0; i < POLY_WIDTH; i++) begin
            if (WCNT_W'(i / NUM_OF_STEPS) == wcnt) begin
                seed_next[i] = din[i % NUM_OF_STEPS];
            end
        end
    end

    // Sync FSM, seed capture, descrambling and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            mcnt       <= '0;
            wcnt       <= '0;
            seed_sh    <= '0;
            lfsr_state <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            locked     <= 1'b0;
            seed_err   <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (resync) begin
                state      <= HUNT;
                mcnt       <= '0;
                wcnt       <= '0;
                seed_sh    <= '0;
                lfsr_state <= '0;
                locked     <= 1'b0;
                seed_err   <= 1'b0;
            end else if (din_valid) begin
                unique case (state)
                    HUNT: begin
                        if (din == SYNC_PATTERN) begin
                            if (mcnt == MCNT_W'(SYNC_REPEAT - 1)) begin
                                state <= LOAD;
                                mcnt  <= '0;
                                wcnt  <= '0;
                            end else begin
                                mcnt <= mcnt + MCNT_W'(1);
                            end
                        end else begin
                            mcnt <= '0;
                        end
                    end
                    LOAD: begin
                        seed_sh <= seed_next;
                        if (wcnt == WCNT_W'(SEED_BEATS - 1)) begin
                            wcnt <= '0;
                            if (seed_next == '0) begin
                                seed_err <= 1'b1;
                                state    <= HUNT;
                            end else begin
                                lfsr_state <= seed_next;
                                locked     <= 1'b1;
                                state      <= RUN;
                            end
                        end else begin
                            wcnt <= wcnt + WCNT_W'(1);
                        end
                    end
                    RUN: begin
                        dout       <= din ^ ks;
                        dout_valid <= 1'b1;
                        lfsr_state <= s_end;
                    end
                    default: begin
                        state <= HUNT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_descrambler_sync.sv
// Scoreboard bench for lfsr_descrambler_sync: directed lock/seed/resync cases plus a model-driven run.
module tb_lfsr_descrambler_sync;

    localparam int unsigned W = 195;
    localparam int unsigned B = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         resync = 1'b0;
    logic         din_valid = 1'b0;
    logic [B-1:0] din = '0;
    logic         dout_valid;
    logic [B-1:0] dout;
    logic         locked;
    logic         seed_err;
    logic [W-1:0] lfsr_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [B-1:0] exp_q[$];

    lfsr_descrambler_sync dut (
        .clk(clk), .rst(rst), .resync(resync), .din_valid(din_valid), .din(din),
        .dout_valid(dout_valid), .dout(dout), .locked(locked), .seed_err(seed_err),
        .lfsr_state(lfsr_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented output beat is matched against the expected queue.
    always @(negedge clk) begin
        if (dout_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_dout: got %0h want none", dout);
            end else begin
                logic [B-1:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    n_err++;
                    $display("FAIL dout: got %0h want %0h", dout, e);
                end
            end
        end
    end

    function automatic logic [W-1:0] model_step(input logic [W-1:0] s);
        logic [W-1:0] n;
        for (int k = 1; k < int'(W); k++) n[k] = s[k-1];
        n[0]  = s[W-1];
        n[28] = s[27] ^ s[W-1];
        n[41] = s[40] ^ s[W-1];
        n[68] = s[67] ^ s[W-1];
        return n;
    endfunction

    task automatic beat(input logic [B-1:0] d);
        din       = d;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic markers();
        beat(10'h17C);
        beat(10'h17C);
    endtask

    // Sends seed beats first..last-1 (k indexes 10-bit slices of the seed).
    task automatic send_seed_range(input logic [W-1:0] seed, input int first, input int last);
        logic [B-1:0] d;
        for (int k = first; k < last; k++) begin
            d = '0;
            for (int b = 0; b < int'(B); b++) begin
                if (k * int'(B) + b < int'(W)) d[b] = seed[k*int'(B)+b];
            end
            beat(d);
        end
    endtask

    task automatic do_resync();
        resync = 1'b1;
        @(posedge clk);
        #1;
        resync = 1'b0;
    endtask

    logic [W-1:0] seed;
    logic [W-1:0] ms;
    logic [W-1:0] tmp;
    logic [B-1:0] pt;
    logic [B-1:0] ks;

    initial begin
        // Reset values
        idle(2);
        check("rst_lfsr", lfsr_state, '0);
        check("rst_locked", W'(locked), '0);
        check("rst_seed_err", W'(seed_err), '0);
        check("rst_dout_valid", W'(dout_valid), '0);
        check("rst_dout", W'(dout), '0);
        rst = 1'b0;
        idle(1);

        // 1: seed = MSB only; first beat keystream bit 0 set, rest zero
        seed = '0;
        seed[W-1] = 1'b1;
        markers();
        send_seed_range(seed, 0, 20);
        check("t1_locked", W'(locked), W'(1));
        check("t1_seed", lfsr_state, seed);
        exp_q.push_back(10'h001);
        beat(10'h000);
        tmp = '0;
        tmp[9] = 1'b1; tmp[37] = 1'b1; tmp[50] = 1'b1; tmp[77] = 1'b1;
        check("t1_state_after_beat", lfsr_state, tmp);
        exp_q.push_back(10'h000);
        beat(10'h000);
        idle(1);
        do_resync();
        check("t1_resync_lfsr", lfsr_state, '0);

        // 2: seed = 1; keystream zero, single bit shifts up by 10 per beat
        seed = W'(1);
        markers();
        send_seed_range(seed, 0, 20);
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(10'h3FF);
            beat(10'h3FF);
            check("t2_state_shift", lfsr_state, W'(1) << (10 * i));
        end
        idle(1);
        do_resync();

        // 3: broken marker run restarts the hunt
        beat(10'h17C);
        beat(10'h000);
        beat(10'h17C);
        beat(10'h17C);
        seed = W'(195'h5_0000_0000_0000_1234_5678_9ABC_DEF0_0000_0000_0000_0042);
        send_seed_range(seed, 0, 19);
        check("t3_not_locked_yet", W'(locked), '0);
        send_seed_range(seed, 19, 20);
        check("t3_locked", W'(locked), W'(1));
        check("t3_seed", lfsr_state, seed);
        idle(1);
        do_resync();

        // 4: all-zero seed flags error and returns to hunt; relock keeps the sticky flag
        markers();
        send_seed_range('0, 0, 20);
        check("t4_seed_err", W'(seed_err), W'(1));
        check("t4_unlocked", W'(locked), '0);
        seed = '0;
        seed[W-1] = 1'b1;
        markers();
        send_seed_range(seed, 0, 20);
        check("t4_relocked", W'(locked), W'(1));
        check("t4_err_sticky", W'(seed_err), W'(1));
        exp_q.push_back(10'h001);
        beat(10'h000);
        idle(1);
        do_resync();
        check("t4_err_cleared", W'(seed_err), '0);
        check("t4_resync_unlock", W'(locked), '0);

        // 5: random seed and plaintext through a reference scrambler, with idle gaps
        for (int b = 0; b < int'(W); b++) seed[b] = 1'($urandom_range(0, 1));
        seed[3] = 1'b1;
        markers();
        send_seed_range(seed, 0, 20);
        ms = seed;
        for (int n = 0; n < 200; n++) begin
            pt = B'($urandom_range(0, 1023));
            for (int j = 0; j < int'(B); j++) begin
                ks[j] = ms[W-1];
                ms = model_step(ms);
            end
            exp_q.push_back(pt);
            beat(pt ^ ks);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
        check("t5_final_state", lfsr_state, ms);
        do_resync();

        // 6: resync mid-LOAD drops the beat; async reset mid-RUN clears everything
        seed = W'(1);
        markers();
        send_seed_range(seed, 0, 10);
        din = 10'h155;
        din_valid = 1'b1;
        resync = 1'b1;
        @(posedge clk);
        #1;
        resync = 1'b0;
        din_valid = 1'b0;
        check("t6_resync_lfsr", lfsr_state, '0);
        check("t6_resync_locked", W'(locked), '0);
        markers();
        send_seed_range(seed, 0, 20);
        check("t6_relock", W'(locked), W'(1));
        exp_q.push_back(10'h2A5);
        beat(10'h2A5);
        idle(1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_locked", W'(locked), '0);
        check("t6_rst_lfsr", lfsr_state, '0);
        check("t6_rst_dout_valid", W'(dout_valid), '0);
        idle(1);
        rst = 1'b0;
        seed = '0;
        seed[W-1] = 1'b1;
        markers();
        send_seed_range(seed, 0, 20);
        check("t6_final_lock", W'(locked), W'(1));
        exp_q.push_back(10'h001);
        beat(10'h000);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1);
        check("queue_drained", W'(exp_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
